// File: rtl/rca_pipe_if.sv
// Handshake and operand/result bundle for the pipelined ripple-carry adder.
// master drives operands and out_ready; slave is the adder itself.
interface rca_pipe_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;

  modport master (
    output in_valid, a, b, ci, sub, out_ready,
    input  in_ready, out_valid, s, co, ovf
  );

  modport slave (
    input  in_valid, a, b, ci, sub, out_ready,
    output in_ready, out_valid, s, co, ovf
  );
endinterface

// File: rtl/rca_pipe.sv
// Pipelined ripple-carry adder/subtractor. WIDTH is resolved SLICE bits per
// stage; each slice carry is registered into the next stage, so the critical
// path is one SLICE-bit add regardless of WIDTH. Latency is STAGES cycles.
// One global enable stalls the whole pipe; bubbles are not collapsed.
module rca_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  rca_pipe_if.slave   bus
);

  localparam int unsigned STAGES = WIDTH / SLICE;
  localparam int unsigned LAST   = STAGES - 1;
  localparam int unsigned MSB    = WIDTH - 1;

  logic             w_en;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_c_eff;

  // Pipe advances when the output slot is empty or being drained.
  assign w_en         = !g_stage[LAST].r_vld || bus.out_ready;
  assign bus.in_ready = w_en;

  // Subtraction folds into addition: a - b - ci = a + ~b + ~ci.
  assign w_b_eff = bus.sub ? ~bus.b  : bus.b;
  assign w_c_eff = bus.sub ? ~bus.ci : bus.ci;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             w_v_src;
    logic             w_c_src;
    logic [WIDTH-1:0] w_a_src;
    logic [WIDTH-1:0] w_b_src;
    logic [WIDTH-1:0] w_s_src;
    logic [WIDTH-1:0] w_s_nxt;
    logic [SLICE:0]   w_slice;

    logic             r_vld;
    logic             r_c;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_s;

    if (k == 0) begin : g_first
      assign w_v_src = bus.in_valid;
      assign w_c_src = w_c_eff;
      assign w_a_src = bus.a;
      assign w_b_src = w_b_eff;
      assign w_s_src = '0;
    end else begin : g_rest
      assign w_v_src = g_stage[k-1].r_vld;
      assign w_c_src = g_stage[k-1].r_c;
      assign w_a_src = g_stage[k-1].r_a;
      assign w_b_src = g_stage[k-1].r_b;
      assign w_s_src = g_stage[k-1].r_s;
    end

    assign w_slice = {1'b0, w_a_src[k*SLICE +: SLICE]}
                   + {1'b0, w_b_src[k*SLICE +: SLICE]}
                   + {{SLICE{1'b0}}, w_c_src};

    // Merge this stage's slice into the result bits carried from earlier stages.
    always_comb begin
      w_s_nxt                    = w_s_src;
      w_s_nxt[k*SLICE +: SLICE]  = w_slice[SLICE-1:0];
    end

    // Stage register: valid, slice carry, skewed operands and partial result.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld <= 1'b0;
        r_c   <= 1'b0;
        r_a   <= '0;
        r_b   <= '0;
        r_s   <= '0;
      end else if (w_en) begin
        r_vld <= w_v_src;
        r_c   <= w_slice[SLICE];
        r_a   <= w_a_src;
        r_b   <= w_b_src;
        r_s   <= w_s_nxt;
      end
    end
  end

  assign bus.out_valid = g_stage[LAST].r_vld;
  assign bus.s         = g_stage[LAST].r_s;
  assign bus.co        = g_stage[LAST].r_c;
  // Operand MSBs ride to the last stage only to form the overflow flag.
  assign bus.ovf       = (g_stage[LAST].r_a[MSB] == g_stage[LAST].r_b[MSB]) &&
                         (g_stage[LAST].r_s[MSB] != g_stage[LAST].r_a[MSB]);

endmodule

// File: tb/tb_rca_pipe.sv
// Scoreboard bench for rca_pipe (WIDTH=16, SLICE=4). Inputs are driven 1ns
// after the rising edge, outputs sampled on the falling edge.
module tb_rca_pipe;
  localparam int W  = 16;
  localparam int SL = 4;
  localparam int ST = W / SL;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        sub;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rca_pipe_if #(.WIDTH(W)) bus ();

  rca_pipe #(.WIDTH(W), .SLICE(SL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [17:0] exp_q[$];  // {ovf, co, s}

  // Reference from integer arithmetic, independent of the slice structure.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic ci, input logic sub);
    int          ua, ub, ur, sa, sb, sr;
    logic        co, ovf;
    logic [15:0] s;
    ua = a;
    ub = b;
    sa = $signed(a);
    sb = $signed(b);
    if (!sub) begin
      ur = ua + ub + int'(ci);
      sr = sa + sb + int'(ci);
      co = (ur > 65535);
    end else begin
      ur = ua - ub - int'(ci);
      sr = sa - sb - int'(ci);
      co = (ur >= 0);
    end
    s   = ur[15:0];
    ovf = (sr > 32767) || (sr < -32768);
    return {ovf, co, s};
  endfunction

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic sub, input logic ordy);
    bus.in_valid  = v;
    bus.a         = a;
    bus.b         = b;
    bus.ci        = ci;
    bus.sub       = sub;
    bus.out_ready = ordy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    #12;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    n_cmp++;
    if ({bus.out_valid, bus.ovf, bus.co, bus.s} !== 19'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b ovf=%b co=%b s=%h want all 0",
               bus.out_valid, bus.ovf, bus.co, bus.s);
    end
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release: got v=%b rdy=%b want v=0 rdy=1", bus.out_valid, bus.in_ready);
    end
  endtask

  // One add; out_valid must be high in exactly cycle ST after acceptance.
  task automatic test_single();
    logic [17:0] e;
    for (int c = 0; c < 8; c++) begin
      drive(c == 0, 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      if (c == 0) begin
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
          n_err++; $display("FAIL single_in_ready: got %b want 1", bus.in_ready);
        end
      end else begin
        n_cmp++;
        if (bus.out_valid !== (c == ST)) begin
          n_err++;
          $display("FAIL single_latency c=%0d: got v=%b want %b", c, bus.out_valid, c == ST);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL single_extra: got s=%h with nothing expected", bus.s);
        end else begin
          e = exp_q.pop_front();
          if ({bus.ovf, bus.co, bus.s} !== e) begin
            n_err++;
            $display("FAIL single_result: got ovf=%b co=%b s=%h want ovf=%b co=%b s=%h",
                     bus.ovf, bus.co, bus.s, e[17], e[16], e[15:0]);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.a, bus.b, bus.ci, bus.sub));
      next_cycle();
    end
  endtask

  // Carry ripple across all slices, overflow, and subtract corners.
  task automatic test_vectors();
    vec_t        v[5];
    logic [17:0] e;
    int          got = 0;
    v[0] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0};
    v[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0};
    v[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1};
    v[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1};
    v[4] = '{16'h0010, 16'h0003, 1'b1, 1'b1};
    for (int c = 0; c < 12; c++) begin
      if (c < 5) drive(1'b1, v[c].a, v[c].b, v[c].ci, v[c].sub, 1'b1);
      else       drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL vec_extra: got s=%h with nothing expected", bus.s);
        end else begin
          e = exp_q.pop_front();
          got++;
          if ({bus.ovf, bus.co, bus.s} !== e) begin
            n_err++;
            $display("FAIL vec_result%0d: got ovf=%b co=%b s=%h want ovf=%b co=%b s=%h",
                     got, bus.ovf, bus.co, bus.s, e[17], e[16], e[15:0]);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.a, bus.b, bus.ci, bus.sub));
      next_cycle();
    end
    n_cmp++;
    if (got != 5 || exp_q.size() != 0) begin
      n_err++; $display("FAIL vec_count: got %0d results want 5", got);
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] e;
    int          got = 0;
    for (int c = 0; c < 14; c++) begin
      if (c < 8) drive(1'b1, 16'(c), 16'(16'h0100 * c), 1'b0, 1'b0, 1'b1);
      else       drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      if (c < 8) begin
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
          n_err++; $display("FAIL b2b_in_ready c=%0d: got %b want 1", c, bus.in_ready);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL b2b_extra: got s=%h with nothing expected", bus.s);
        end else begin
          e = exp_q.pop_front();
          if ({bus.ovf, bus.co, bus.s} !== e || c != got + ST) begin
            n_err++;
            $display("FAIL b2b_result%0d: got s=%h co=%b at cycle %0d want s=%h co=%b at cycle %0d",
                     got, bus.s, bus.co, c, e[15:0], e[16], got + ST);
          end
          got++;
        end
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.a, bus.b, bus.ci, bus.sub));
      next_cycle();
    end
    n_cmp++;
    if (got != 8) begin
      n_err++; $display("FAIL b2b_count: got %0d results want 8", got);
    end
  endtask

  // out_ready drops for cycles 4..6, exactly when the first result appears.
  task automatic test_backpressure();
    logic [17:0] e;
    logic [16:0] snap;
    int          idx = 0;
    int          got = 0;
    logic        stall;
    for (int c = 0; c < 20; c++) begin
      stall = (c >= 4) && (c <= 6);
      if (idx < 6) drive(1'b1, 16'(16'h1111 * (idx + 1)), 16'(16'h0F0F + idx), 1'(idx & 1),
                         1'((idx >> 1) & 1), !stall);
      else         drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, !stall);
      @(negedge clk);
      if (stall) begin
        if (c == 4) snap = {bus.co, bus.s};
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || {bus.co, bus.s} !== snap) begin
          n_err++;
          $display("FAIL bp_stall c=%0d: got v=%b rdy=%b co=%b s=%h want v=1 rdy=0 co=%b s=%h",
                   c, bus.out_valid, bus.in_ready, bus.co, bus.s, snap[16], snap[15:0]);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL bp_extra: got s=%h with nothing expected", bus.s);
        end else begin
          e = exp_q.pop_front();
          got++;
          if ({bus.ovf, bus.co, bus.s} !== e) begin
            n_err++;
            $display("FAIL bp_result%0d: got ovf=%b co=%b s=%h want ovf=%b co=%b s=%h",
                     got, bus.ovf, bus.co, bus.s, e[17], e[16], e[15:0]);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.a, bus.b, bus.ci, bus.sub));
        idx++;
      end
      next_cycle();
    end
    n_cmp++;
    if (got != 6 || exp_q.size() != 0) begin
      n_err++; $display("FAIL bp_count: got %0d results want 6", got);
    end
  endtask

  task automatic test_reset_mid();
    logic [17:0] e;
    // Three accepts, then reset lands between edges with them in flight.
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 16'(16'h0A0A + c), 16'h0505, 1'b0, 1'b0, 1'b1);
      next_cycle();
    end
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.out_valid, bus.ovf, bus.co, bus.s} !== 19'h0 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_clear: got v=%b ovf=%b co=%b s=%h rdy=%b want 0s and rdy=1",
               bus.out_valid, bus.ovf, bus.co, bus.s, bus.in_ready);
    end
    exp_q.delete();
    next_cycle();
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    // Nothing stale may emerge; a fresh add retires exactly ST cycles later.
    for (int c = 0; c < 10; c++) begin
      drive(c == 0, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      if (c > 0) begin
        n_cmp++;
        if (bus.out_valid !== (c == ST)) begin
          n_err++;
          $display("FAIL rstmid_latency c=%0d: got v=%b want %b", c, bus.out_valid, c == ST);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL rstmid_stale: got s=%h with nothing expected", bus.s);
        end else begin
          e = exp_q.pop_front();
          if ({bus.ovf, bus.co, bus.s} !== e) begin
            n_err++;
            $display("FAIL rstmid_result: got s=%h co=%b want s=%h co=%b",
                     bus.s, bus.co, e[15:0], e[16]);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.a, bus.b, bus.ci, bus.sub));
      next_cycle();
    end
    // Reset while a nonzero result is held at the output under stall.
    for (int c = 0; c < ST + 1; c++) begin
      drive(c == 0, 16'hABCD, 16'h1111, 1'b1, 1'b0, 1'b0);
      next_cycle();
    end
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.s !== 16'hBCDF) begin
      n_err++;
      $display("FAIL rstmid_held: got v=%b s=%h want v=1 s=bcdf", bus.out_valid, bus.s);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.out_valid, bus.ovf, bus.co, bus.s} !== 19'h0 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_clear2: got v=%b ovf=%b co=%b s=%h rdy=%b want 0s and rdy=1",
               bus.out_valid, bus.ovf, bus.co, bus.s, bus.in_ready);
    end
    exp_q.delete();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_vectors();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rca_pipe.md
Name: rca_pipe

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor. Successor to the fixed 4-bit combinational ripple-carry adder cell.
- Operand width is split into SLICE-bit slices. Each slice's ripple carry is registered into the next pipeline stage, so the clock rate is independent of WIDTH.
- Valid/ready handshake on input and output. Sits between datapath register stages wherever wide add/sub is needed.

Parameters:
- WIDTH, 16, operand and sum width in bits. Must be an integer multiple of SLICE, and at least SLICE.
- SLICE, 4, bits resolved per pipeline stage.
- STAGES (derived, localparam), WIDTH/SLICE, pipeline depth and latency in cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- ci  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- s  output  WIDTH  sum or difference.
- co  output  1  carry-out (add) / not-borrow (sub).
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Arithmetic:
  - b_eff = sub ? ~b : b.
  - c_eff = sub ? ~ci : ci.
  - {co, s} = a + b_eff + c_eff, computed mod 2^(WIDTH+1).
  - ovf = (a[MSB] == b_eff[MSB]) && (s[MSB] != a[MSB]).
  - For sub, s = a - b - ci. co = 1 means no borrow.
- Input capture:
  - A transfer occurs when in_valid && in_ready at a rising edge.
  - a, b_eff and c_eff are captured with the transaction's valid bit into stage 0.
- Stage k (k = 0..STAGES-1):
  - Adds slice k of the skewed operands plus the carry registered from stage k-1. Stage 0 uses c_eff.
  - Registers the slice sum bits, the slice carry and the valid bit.
  - Operand slices above k travel in delay registers alongside the transaction.
  - Result slices below k travel in delay registers alongside the transaction.
- Latency: a transfer accepted at edge T presents out_valid=1 with its result after edge T+STAGES-1. This is the first cycle in which that transaction's data is visible on the outputs, STAGES cycles after acceptance. Example: WIDTH=16, SLICE=4, accept at cycle 0, result visible in cycle 4.
- Flow control: global enable en = !out_valid || out_ready.
  - in_ready = en, combinational. There is no combinational path from in_valid to in_ready.
  - When en=0, every stage register holds, including valid bits, so s, co and ovf are stable.
  - When en=1, all stages shift by one.
  - Bubbles are not collapsed: an empty stage still costs one cycle.
- Throughput: 1 transaction per cycle while out_ready=1.
- Ordering is strictly FIFO. No transaction is dropped or duplicated.
- Stall while out_valid=1 and out_ready=0:
  - s, co, ovf hold.
  - in_ready=0, so upstream must hold its operands.
- Simultaneous accept and retire in the same cycle is allowed with en=1. This is the steady-state throughput case.
- Reset (asynchronous, any time, including mid-pipeline):
  - All valid bits are cleared and all data registers go to 0. In-flight transactions are discarded.
  - out_valid=0, s=0, co=0, ovf=0.
  - in_ready=1 while rst_n=0 and after release.
  - After release, the first accept obeys normal latency.
- Degenerate case WIDTH=SLICE: STAGES=1, a single registered adder with latency 1.
- Wrap: results are taken mod 2^WIDTH, with carry in co. No saturation.

Test Plan (WIDTH=16, SLICE=4):
- Add, single transaction:
  - Stimulus: a=0x1234, b=0x4321, ci=0, sub=0, accept at cycle 0, out_ready=1.
  - Required: cycle 4 shows out_valid=1, s=0x5555, co=0, ovf=0. Cycle 5 shows out_valid=0.
- Full carry ripple across all slices:
  - Stimulus: a=0xFFFF, b=0x0000, ci=1.
  - Required: s=0x0000, co=1, ovf=0.
  - Stimulus: a=0x7FFF, b=0x0001, ci=0.
  - Required: s=0x8000, co=0, ovf=1.
- Subtract:
  - Stimulus: a=0x0005, b=0x0007, ci=0, sub=1.
  - Required: s=0xFFFE, co=0 (borrow).
  - Stimulus: a=0x8000, b=0x0001, sub=1, ci=0.
  - Required: s=0x7FFF, co=1, ovf=1.
  - Stimulus: a=0x0010, b=0x0003, ci=1, sub=1.
  - Required: s=0x000C, co=1.
- Back-to-back stream:
  - Stimulus: 8 transactions on consecutive cycles, a=i, b=0x0100*i, out_ready=1.
  - Required: results in order on cycles 4..11, s=0x0101*i, one per cycle, in_ready held at 1.
- Backpressure:
  - Stimulus: stream 6 transactions, drop out_ready for 3 cycles when the first result appears.
  - Required:
    - out_valid, s and co stable during the stall.
    - in_ready=0 during the stall.
    - After release, all 6 results arrive in order with none lost or duplicated.
- Reset mid-operation:
  - Stimulus: accept 3 transactions, assert rst_n=0 asynchronously between edges at cycle 2, release at cycle 4.
  - Required:
    - out_valid, s, co, ovf = 0 immediately on assertion.
    - No stale results emerge afterwards.
    - A new add a=0x0001, b=0x0001 yields s=0x0002 exactly 4 cycles after its accept.
